fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 29 ++
 rtl/fetch_queue.sv | 112 +++++++++++
 tb/tb_fetch_queue.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue signal bundle: instruction-memory request/response, redirect, and decode handshake.
// master = fetch_queue, slave = memory/decode environment.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Credit-based instruction prefetch queue: issues sequential fetches, buffers in-order
// responses with their PCs, and flushes/discards stale responses on redirect.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master fq
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          buf_q [DEPTH];
  entry_t          buf_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;

  logic [XLEN-1:0] redir_tgt;
  logic [CW:0]     inflight;
  logic            req_fire;
  logic            resp_in;
  logic            push;
  logic            pop;

  // Buffered + outstanding never exceeds DEPTH, so every outstanding response owns a slot.
  always_comb begin
    redir_tgt         = {fq.redirect_pc[XLEN-1:2], 2'b00};
    inflight          = {1'b0, count_q} + {1'b0, outst_q};
    fq.imem_req_valid = !rst && !fq.redirect_valid && (inflight < DEPTH_C);
    fq.imem_req_addr  = fetch_pc_q;
    req_fire          = fq.imem_req_valid && fq.imem_req_ready;
    resp_in           = fq.imem_resp_valid && (outst_q != '0);
    push              = resp_in && !fq.redirect_valid && (discard_q == '0);
    fq.if_valid       = !rst && (count_q != '0);
    pop               = fq.if_valid && fq.if_ready && !fq.redirect_valid;
    fq.if_instr       = buf_q[rd_ptr_q].instr;
    fq.if_pc          = buf_q[rd_ptr_q].pc;
  end

  always_comb begin
    buf_d      = buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    outst_d    = outst_q + CW'(req_fire) - CW'(resp_in);
    discard_d  = discard_q;

    if (push) begin
      buf_d[wr_ptr_q] = '{instr: fq.imem_resp_data, pc: resp_pc_q};
      wr_ptr_d        = wr_ptr_q + PW'(1);
      resp_pc_d       = resp_pc_q + XLEN'(4);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + PW'(1);
    if (req_fire)
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (resp_in && (discard_q != '0))
      discard_d = discard_q - CW'(1);

    // Everything still in flight belongs to the old path; a response landing now is dropped too.
    if (fq.redirect_valid) begin
      fetch_pc_d = redir_tgt;
      resp_pc_d  = redir_tgt;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      discard_d  = outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
    end
  end

  // Storage needs no reset: entries are only observable once count is nonzero.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: in-order memory model with variable latency,
// epoch-tagged requests for redirect discards, and an independent output monitor.
module tb_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(XLEN)) fif ();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst(rst),
    .fq (fif)
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mreq_t pend[$];
  exp_t  exp_q[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, epoch = 0, buffered = 0, accepts = 0, pops = 0;
  int p_ready, p_resp, lat_max, p_ifr, p_redir;
  bit rst_req = 1'b1, force_redir = 1'b0, want_first = 1'b0;
  logic [31:0] force_tgt, model_pc = RESET_PC, first_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic knobs(input int r, input int rs, input int lat, input int ifr, input int rd);
    p_ready = r; p_resp = rs; lat_max = lat; p_ifr = ifr; p_redir = rd;
  endtask

  // One clock cycle: drive inputs at negedge, then observe handshakes and advance the model.
  task automatic step();
    mreq_t m;
    bit    redir, pop, exp_rv;
    @(negedge clk);
    rst = rst_req;
    fif.redirect_valid  = 1'b0;
    fif.redirect_pc     = '0;
    fif.imem_resp_valid = 1'b0;
    fif.imem_resp_data  = '0;
    if (!rst_req) begin
      if (force_redir) begin
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = force_tgt;
        force_redir        = 1'b0;
      end else if (int'($urandom_range(99)) < p_redir) begin
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = $urandom & 32'h0000_FFFF;
      end
      if (pend.size() > 0 && pend[0].due <= cyc && int'($urandom_range(99)) < p_resp) begin
        fif.imem_resp_valid = 1'b1;
        fif.imem_resp_data  = mem_data(pend[0].addr);
      end
    end
    fif.imem_req_ready = (int'($urandom_range(99)) < p_ready);
    fif.if_ready       = (int'($urandom_range(99)) < p_ifr);
    #1;
    if (rst) begin
      check("rst_req_valid", fif.imem_req_valid, 0);
      check("rst_if_valid", fif.if_valid, 0);
      pend.delete();
      exp_q.delete();
      buffered = 0;
      model_pc = RESET_PC;
      epoch++;
    end else begin
      redir  = fif.redirect_valid;
      exp_rv = !redir && ((buffered + pend.size()) < DEPTH);
      check("if_valid", fif.if_valid, buffered > 0);
      check("req_valid", fif.imem_req_valid, exp_rv);
      check("credit", (buffered + pend.size()) <= DEPTH, 1);
      pop = fif.if_valid && fif.if_ready && !redir;
      if (redir) begin
        epoch++;
        exp_q.delete();
        buffered   = 0;
        model_pc   = {fif.redirect_pc[31:2], 2'b00};
        want_first = 1'b1;
      end else if (pop) begin
        buffered--;
      end
      if (fif.imem_req_valid && fif.imem_req_ready) begin
        check("req_addr", fif.imem_req_addr, model_pc);
        pend.push_back('{fif.imem_req_addr, epoch, cyc + int'($urandom_range(1, lat_max))});
        exp_q.push_back('{model_pc, mem_data(model_pc)});
        model_pc += 4;
        accepts++;
      end
      if (fif.imem_resp_valid) begin
        m = pend.pop_front();
        if (m.epoch == epoch) buffered++;
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_req = 1'b1;
    repeat (n) step();
    rst_req = 1'b0;
    step();
    check("first_req_valid", fif.imem_req_valid, 1);
    check("first_req_addr", fif.imem_req_addr, RESET_PC);
  endtask

  // Output monitor: every pop must match the head of the expected stream.
  always @(negedge clk) begin : mon
    exp_t e;
    #2;
    if (!rst && fif.if_valid && fif.if_ready && !fif.redirect_valid) begin
      pops++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_unexpected: got pc %h expected no output", fif.if_pc);
      end else begin
        e = exp_q.pop_front();
        check("if_pc", fif.if_pc, e.pc);
        check("if_instr", fif.if_instr, e.instr);
        if (want_first) begin
          first_pc   = fif.if_pc;
          want_first = 1'b0;
        end
      end
    end
  end

  initial begin
    int p0, a0;
    fif.imem_req_ready = 1'b0; fif.imem_resp_valid = 1'b0; fif.imem_resp_data = '0;
    fif.redirect_valid = 1'b0; fif.redirect_pc = '0; fif.if_ready = 1'b0;

    // Streaming with single-cycle memory: one instruction per cycle once filled.
    knobs(100, 100, 1, 100, 0);
    do_reset(2);
    repeat (10) step();
    p0 = pops;
    repeat (10) step();
    check("throughput", pops - p0, 10);

    // Decode stalled: exactly DEPTH requests accepted, then request valid drops.
    knobs(100, 100, 1, 0, 0);
    do_reset(1);
    a0 = accepts - 1;
    repeat (12) step();
    check("sat_accepts", accepts - a0, DEPTH);
    check("sat_req_valid", fif.imem_req_valid, 0);
    check("sat_if_valid", fif.if_valid, 1);

    // Redirect with two requests outstanding.
    knobs(100, 0, 1, 0, 0);
    do_reset(1);
    step();
    check("pre_redir_outst", pend.size(), 2);
    first_pc    = 32'hFFFF_FFFF;
    force_tgt   = 32'h0000_0103;
    force_redir = 1'b1;
    step();
    knobs(100, 100, 1, 100, 0);
    step();
    check("redir_addr", fif.imem_req_addr, 32'h0000_0100);
    repeat (15) step();
    check("redir_first_pc", first_pc, 32'h0000_0100);

    // Redirect coinciding with a response and a decode pop.
    knobs(100, 0, 1, 0, 0);
    do_reset(1);
    repeat (3) step();
    knobs(0, 100, 1, 0, 0);
    repeat (3) step();
    knobs(0, 100, 1, 100, 0);
    force_tgt   = 32'h0000_0200;
    force_redir = 1'b1;
    step();
    check("r037_if_valid_before", fif.if_valid, 1);
    knobs(100, 100, 1, 100, 0);
    step();
    check("r037_if_valid_after", fif.if_valid, 0);
    repeat (10) step();

    // Random traffic in several regimes.
    knobs(70, 80, 5, 70, 3);   repeat (800) step();
    knobs(100, 100, 5, 20, 2); repeat (800) step();
    knobs(30, 50, 5, 100, 5);  repeat (800) step();
    knobs(90, 90, 2, 90, 1);   repeat (800) step();

    // Reset with a loaded buffer and requests still in flight.
    knobs(100, 100, 3, 0, 0);
    repeat (8) step();
    check("pre_rst_if_valid", fif.if_valid, 1);
    rst_req = 1'b1;
    step();
    step();
    check("mid_rst_if_valid", fif.if_valid, 0);
    check("mid_rst_req_valid", fif.imem_req_valid, 0);
    knobs(80, 80, 4, 80, 2);
    do_reset(1);
    repeat (400) step();

    // Drain: stop fetching and confirm nothing was lost.
    knobs(0, 100, 1, 100, 0);
    for (int i = 0; i < 80 && (exp_q.size() != 0 || pend.size() != 0); i++) step();
    check("drain_exp_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
